hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that generates the `stall`, `flush` and `Stall_DM` controls consumed by the IF/ID and ID/EX pipeline registers, plus PC and IF/ID write enables.
- Detects load-use hazards combinationally from ID and EX register fields.
- Sequences multi-cycle flush windows after a taken branch or jump resolved in EX.
- Defers redirects that arrive while the data memory is busy.
- Latches HALT.
- Keeps saturating performance counters for stall cycles and flush events.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` is asserted per accepted redirect; legal range 1..7.
- CNT_W, 16, width of the performance counters.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- IFID_rs  in  3  source register 1 of the instruction in ID.
- IFID_rs_used  in  1  ID instruction reads rs.
- IFID_rt  in  3  source register 2 of the instruction in ID.
- IFID_rt_used  in  1  ID instruction reads rt.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_writeRegSel  in  3  destination register of the instruction in EX.
- redirect  in  1  taken branch or jump resolved in EX this cycle.
- halt_ex  in  1  HALT is in EX this cycle.
- dm_busy  in  1  data memory not ready; the whole pipeline must freeze.
- stall  out  1  insert bubble into ID/EX; hold PC and IF/ID.
- flush  out  1  squash IF/ID and ID/EX contents.
- Stall_DM  out  1  freeze all pipeline registers.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- halted  out  1  core halted; sticky until reset.
- stall_cycles  out  CNT_W  saturating count of cycles with `stall` or `Stall_DM` asserted.
- flush_events  out  CNT_W  saturating count of accepted redirects.

## Operation
- Load-use term:
  - lu = IDEX_MemRead & ((IFID_rs_used & IFID_rs==IDEX_writeRegSel) | (IFID_rt_used & IFID_rt==IDEX_writeRegSel)).
- State: FSM {RUN, FLUSH, HALT}, a 3-bit flush counter `fcnt`, and a `pend` flag (deferred redirect).
- Priority each cycle: reset > HALT state > dm_busy > redirect/pend/FLUSH > lu > halt_ex > normal.
- HALT state:
  - pc_en=0, ifid_en=0, stall=1, flush=0, halted=1.
  - Stall_DM still follows dm_busy.
  - Only reset exits HALT.
- dm_busy=1 (RUN or FLUSH):
  - Stall_DM=1, pc_en=0, ifid_en=0, stall=0, flush=0.
  - fcnt and state are held.
  - A redirect arriving in this cycle sets pend=1.
- Accept a redirect when dm_busy=0 and (redirect | pend):
  - flush=1, pc_en=1, ifid_en=1, stall=0.
  - fcnt ← FLUSH_CYCLES−1; pend ← 0; flush_events+1.
  - Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
- FLUSH state, dm_busy=0, no new redirect:
  - flush=1, pc_en=1, ifid_en=1.
  - fcnt decrements; at fcnt==1 the next state is RUN.
  - A new redirect restarts the window as an accepted redirect.
- lu in RUN, no redirect/pend, dm_busy=0:
  - stall=1, pc_en=0, ifid_en=0.
  - Suppressed whenever flush is asserted.
- halt_ex in RUN, no flush, no dm_busy, no lu:
  - Next state HALT; current cycle behaves as normal.
- Normal: pc_en=1, ifid_en=1, all hazard outputs 0.
- Counters: saturate at 2^CNT_W−1 and never wrap.

## Timing
- stall, flush, Stall_DM, pc_en, ifid_en: combinational from state and current inputs, same cycle.
- halted, counters, state, fcnt, pend: registered; update on the rising edge of clk.
- rst low, asynchronously:
  - state=RUN, fcnt=0, pend=0, counters=0.
  - All outputs forced to 0, including pc_en and ifid_en; no dependence on dm_busy.
- Redirect latency: flush is asserted in the same cycle as redirect and for exactly FLUSH_CYCLES non-busy cycles.
- Deferred redirect: flush is asserted in the first cycle in which dm_busy=0.
- Simultaneous redirect + lu: flush only, and no stall cycle is counted.
- Simultaneous redirect + halt_ex: redirect wins and HALT is not entered, because the halting instruction is squashed.
- Reset release mid-FLUSH or with pend set: discard both; operation resumes in RUN.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_writeRegSel=3, IFID_rs=3, IFID_rs_used=1 for one cycle -> stall=1, pc_en=0 that cycle; stall_cycles=1.
- Redirect with FLUSH_CYCLES=2: redirect pulse at cycle N -> flush=1 at N and N+1 and 0 at N+2; flush_events=1.
- Deferred redirect: dm_busy=1 for cycles N..N+3 with redirect at N+1 -> flush=0 during N..N+3; flush=1 at N+4 and N+5; Stall_DM=1 at N..N+3; stall_cycles=4.
- Redirect + lu together -> flush=1, stall=0, stall_cycles unchanged.
- Halt: halt_ex=1 one cycle -> halted=1 from the next cycle; pc_en=0 and stall=1 persist; assert rst=0 mid-cycle -> all outputs 0 immediately.
- Saturation with CNT_W=4: 20 consecutive stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush windows, DM freeze, HALT, perf counters
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       IFID_rs,
    input  logic             IFID_rs_used,
    input  logic [2:0]       IFID_rt,
    input  logic             IFID_rt_used,
    input  logic             IDEX_MemRead,
    input  logic [2:0]       IDEX_writeRegSel,
    input  logic             redirect,
    input  logic             halt_ex,
    input  logic             dm_busy,
    output logic             stall,
    output logic             flush,
    output logic             Stall_DM,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] fcnt, fcnt_n;
    logic       pend, pend_n;
    logic       lu;
    logic       stall_c, flush_c, sdm_c, pc_c, ifid_c, accept_c;

    assign lu = IDEX_MemRead &
                ((IFID_rs_used & (IFID_rs == IDEX_writeRegSel)) |
                 (IFID_rt_used & (IFID_rt == IDEX_writeRegSel)));

    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        pend_n   = pend;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        sdm_c    = 1'b0;
        pc_c     = 1'b0;
        ifid_c   = 1'b0;
        accept_c = 1'b0;
        if (state == HALT) begin
            stall_c = 1'b1;
            sdm_c   = dm_busy;
        end else if (dm_busy) begin
            // Frozen pipeline: a redirect seen now must survive until memory is ready.
            sdm_c  = 1'b1;
            pend_n = pend | redirect;
        end else if (redirect || pend) begin
            flush_c  = 1'b1;
            pc_c     = 1'b1;
            ifid_c   = 1'b1;
            accept_c = 1'b1;
            fcnt_n   = FCNT_LOAD;
            pend_n   = 1'b0;
            state_n  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            flush_c = 1'b1;
            pc_c    = 1'b1;
            ifid_c  = 1'b1;
            fcnt_n  = fcnt - 3'd1;
            if (fcnt == 3'd1) begin
                state_n = RUN;
            end
        end else if (lu) begin
            stall_c = 1'b1;
        end else begin
            pc_c   = 1'b1;
            ifid_c = 1'b1;
            if (halt_ex) begin
                state_n = HALT;
            end
        end
    end

    // Held in reset, every control output reads 0 regardless of the inputs.
    assign stall    = rst & stall_c;
    assign flush    = rst & flush_c;
    assign Stall_DM = rst & sdm_c;
    assign pc_en    = rst & pc_c;
    assign ifid_en  = rst & ifid_c;
    assign halted   = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            fcnt         <= 3'd0;
            pend         <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
            pend  <= pend_n;
            if ((stall_c || sdm_c) && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (accept_c && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule
